// File: rtl/spi_tlul_host_arbiter.sv
// Round-robin arbiter sharing one TL-UL host adapter port among NUM_REQ requesters.
// Responses are routed back to their issuer through an in-order ID FIFO.
module spi_tlul_host_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned OST_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*AW-1:0] addr_i,
    input  logic [NUM_REQ-1:0]    we_i,
    input  logic [NUM_REQ*DW-1:0] wdata_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    rvalid_o,
    output logic [DW-1:0]         rdata_o,
    output logic                  rerr_o,
    output logic                  spurious_o,
    output logic                  host_req_o,
    input  logic                  host_gnt_i,
    output logic [AW-1:0]         host_addr_o,
    output logic                  host_we_o,
    output logic [DW-1:0]         host_wdata_o,
    input  logic                  host_valid_i,
    input  logic [DW-1:0]         host_rdata_i,
    input  logic                  host_err_i
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int unsigned CW = $clog2(OST_DEPTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   win;
    logic            found;
    logic [IW-1:0]   win_id;
    logic [IW-1:0]   fifo [OST_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            can_grant;
    logic            grant;

    assign push      = (state == ISSUE) && host_gnt_i;
    assign pop       = host_valid_i && (count != '0);
    // A response popping this cycle frees a slot for the request granted now.
    assign can_grant = (count != CW'(OST_DEPTH)) || pop;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            logic [IW-1:0] cand;
            cand = IW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        gnt_o      = '0;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (found && can_grant) begin
                    grant      = 1'b1;
                    gnt_o      = NUM_REQ'(1) << win;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (host_gnt_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rvalid_o = pop ? (NUM_REQ'(1) << fifo[rd_ptr]) : '0;
    assign rdata_o  = host_rdata_i;
    assign rerr_o   = host_err_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            win_id       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            spurious_o   <= 1'b0;
            host_req_o   <= 1'b0;
            host_addr_o  <= '0;
            host_we_o    <= 1'b0;
            host_wdata_o <= '0;
        end else begin
            state      <= state_next;
            host_req_o <= (state_next == ISSUE);
            if (grant) begin
                win_id       <= win;
                host_addr_o  <= addr_i[32'(win)*AW +: AW];
                host_we_o    <= we_i[win];
                host_wdata_o <= wdata_i[32'(win)*DW +: DW];
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(OST_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                rr_ptr <= (win_id == IW'(NUM_REQ - 1)) ? '0 : win_id + IW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(OST_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (host_valid_i && (count == '0)) begin
                spurious_o <= 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // ID storage needs no reset; entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo[wr_ptr] <= win_id;
        end
    end

endmodule

// File: tb/tb_spi_tlul_host_arbiter.sv
// Bench for spi_tlul_host_arbiter: directed scenarios plus a randomized run
// checked against a queue-based transaction model.
module tb_spi_tlul_host_arbiter;

    localparam int unsigned NR  = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  addr;
    logic [NR-1:0]     we;
    logic [NR*DW-1:0]  wdata;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic              rerr;
    logic              spur;
    logic              hreq;
    logic              hgnt;
    logic [AW-1:0]     haddr;
    logic              hwe;
    logic [DW-1:0]     hwdata;
    logic              hvalid;
    logic [DW-1:0]     hrdata;
    logic              herr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_tlul_host_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .OST_DEPTH(DEP)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .rerr_o(rerr), .spurious_o(spur),
        .host_req_o(hreq), .host_gnt_i(hgnt), .host_addr_o(haddr), .host_we_o(hwe),
        .host_wdata_o(hwdata), .host_valid_i(hvalid), .host_rdata_i(hrdata), .host_err_i(herr)
    );

    task automatic idle_inputs();
        req = '0; addr = '0; we = '0; wdata = '0;
        hgnt = 1'b0; hvalid = 1'b0; hrdata = '0; herr = 1'b0;
    endtask

    // Each test cycle starts at a falling edge: drive, wait #1, compare.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nxt();
        idle_inputs();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        nxt();
        nxt();
        #1;
        total++; if (gnt !== '0)    begin bad++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
        total++; if (rvalid !== '0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        total++; if (hreq !== 1'b0) begin bad++; $display("FAIL reset_hreq got=%b exp=0", hreq); end
        total++; if (haddr !== '0)  begin bad++; $display("FAIL reset_haddr got=%h exp=0", haddr); end
        total++; if (hwe !== 1'b0)  begin bad++; $display("FAIL reset_hwe got=%b exp=0", hwe); end
        total++; if (hwdata !== '0) begin bad++; $display("FAIL reset_hwdata got=%h exp=0", hwdata); end
        total++; if (spur !== 1'b0) begin bad++; $display("FAIL reset_spur got=%b exp=0", spur); end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        req = 2'b01; addr[0 +: AW] = 32'h4000_0010; we = 2'b00; hgnt = 1'b1;
        #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt got=%b exp=01", gnt); end
        nxt();
        req = 2'b00;
        #1;
        total++; if (hreq !== 1'b1) begin bad++; $display("FAIL single_hreq got=%b exp=1", hreq); end
        total++; if (haddr !== 32'h4000_0010) begin bad++; $display("FAIL single_haddr got=%h exp=40000010", haddr); end
        total++; if (hwe !== 1'b0)  begin bad++; $display("FAIL single_hwe got=%b exp=0", hwe); end
        nxt();
        #1;
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL single_early_rvalid got=%b exp=00", rvalid); end
        nxt();
        nxt();
        hvalid = 1'b1; hrdata = 32'hDEAD_BEEF;
        #1;
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL single_rvalid got=%b exp=01", rvalid); end
        total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rdata got=%h exp=deadbeef", rdata); end
        nxt();
        idle_inputs();
    endtask

    task automatic test_fairness();
        logic [NR-1:0] exp;
        do_reset();
        req = 2'b11; hgnt = 1'b1; hvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp = (i % 2 == 1) ? 2'b00 : (((i / 2) % 2 == 1) ? 2'b10 : 2'b01);
            total++; if (gnt !== exp) begin bad++; $display("FAIL fair_gnt cyc=%0d got=%b exp=%b", i, gnt, exp); end
            nxt();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        do_reset();
        a = $urandom; d = $urandom;
        addr[AW +: AW] = a; wdata[DW +: DW] = d; we = 2'b10; req = 2'b10; hgnt = 1'b0;
        #1;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL bp_first_gnt got=%b exp=10", gnt); end
        nxt();
        req = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (hreq !== 1'b1) begin bad++; $display("FAIL bp_hreq cyc=%0d got=%b exp=1", i, hreq); end
            total++; if (haddr !== a)   begin bad++; $display("FAIL bp_haddr cyc=%0d got=%h exp=%h", i, haddr, a); end
            total++; if (hwe !== 1'b1)  begin bad++; $display("FAIL bp_hwe cyc=%0d got=%b exp=1", i, hwe); end
            total++; if (hwdata !== d)  begin bad++; $display("FAIL bp_hwdata cyc=%0d got=%h exp=%h", i, hwdata, d); end
            total++; if (gnt !== 2'b00) begin bad++; $display("FAIL bp_gnt cyc=%0d got=%b exp=00", i, gnt); end
            nxt();
        end
        hgnt = 1'b1;
        #1;
        total++; if (hreq !== 1'b1) begin bad++; $display("FAIL bp_release_hreq got=%b exp=1", hreq); end
        nxt();
        hgnt = 1'b0;
        #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL bp_next_gnt got=%b exp=01", gnt); end
        nxt();
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        logic [DW-1:0] r;
        do_reset();
        hgnt = 1'b1;
        req = 2'b01; #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL full_gnt_a got=%b exp=01", gnt); end
        nxt(); req = 2'b00; nxt();
        req = 2'b10; #1;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL full_gnt_b got=%b exp=10", gnt); end
        nxt(); req = 2'b00; nxt();
        req = 2'b01;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (gnt !== 2'b00) begin bad++; $display("FAIL full_blocked cyc=%0d got=%b exp=00", i, gnt); end
            nxt();
        end
        r = $urandom;
        hvalid = 1'b1; hrdata = r; #1;
        total++; if (gnt !== 2'b01)    begin bad++; $display("FAIL full_gnt_c got=%b exp=01", gnt); end
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL full_rvalid_a got=%b exp=01", rvalid); end
        total++; if (rdata !== r)      begin bad++; $display("FAIL full_rdata got=%h exp=%h", rdata, r); end
        nxt();
        hvalid = 1'b0; req = 2'b00; nxt();
        hvalid = 1'b1; #1;
        total++; if (rvalid !== 2'b10) begin bad++; $display("FAIL full_rvalid_b got=%b exp=10", rvalid); end
        nxt(); #1;
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL full_rvalid_c got=%b exp=01", rvalid); end
        nxt();
        idle_inputs();
    endtask

    task automatic test_push_pop();
        do_reset();
        hgnt = 1'b1;
        req = 2'b01; #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL pp_gnt_a got=%b exp=01", gnt); end
        nxt(); req = 2'b00; nxt();
        req = 2'b10; #1;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL pp_gnt_b got=%b exp=10", gnt); end
        nxt();
        req = 2'b00; hvalid = 1'b1; #1;
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL pp_rvalid_a got=%b exp=01", rvalid); end
        nxt(); #1;
        total++; if (rvalid !== 2'b10) begin bad++; $display("FAIL pp_rvalid_b got=%b exp=10", rvalid); end
        nxt(); #1;
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL pp_rvalid_empty got=%b exp=00", rvalid); end
        nxt();
        hvalid = 1'b0; #1;
        total++; if (spur !== 1'b1) begin bad++; $display("FAIL pp_spur got=%b exp=1", spur); end
        nxt();
        idle_inputs();
    endtask

    task automatic test_spurious_reset();
        do_reset();
        hvalid = 1'b1; #1;
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL sp_rvalid got=%b exp=00", rvalid); end
        nxt();
        hvalid = 1'b0; #1;
        total++; if (spur !== 1'b1) begin bad++; $display("FAIL sp_set got=%b exp=1", spur); end
        nxt();
        req = 2'b01; addr[0 +: AW] = 32'h1234_5678; hgnt = 1'b0; #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL sp_gnt got=%b exp=01", gnt); end
        nxt();
        req = 2'b00; #1;
        total++; if (hreq !== 1'b1) begin bad++; $display("FAIL sp_issue_hreq got=%b exp=1", hreq); end
        rst = 1'b1;
        nxt();
        rst = 1'b0; #1;
        total++; if (hreq !== 1'b0) begin bad++; $display("FAIL sp_rst_hreq got=%b exp=0", hreq); end
        total++; if (spur !== 1'b0) begin bad++; $display("FAIL sp_rst_spur got=%b exp=0", spur); end
        total++; if (haddr !== '0)  begin bad++; $display("FAIL sp_rst_haddr got=%h exp=0", haddr); end
        nxt();
        hvalid = 1'b1; #1;
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL sp_after_rst_rvalid got=%b exp=00", rvalid); end
        nxt();
        hvalid = 1'b0; #1;
        total++; if (spur !== 1'b1) begin bad++; $display("FAIL sp_after_rst_spur got=%b exp=1", spur); end
        nxt();
        idle_inputs();
    endtask

    // Model: one pending grant awaiting the host, a queue of issued IDs, a rotating start index.
    task automatic test_random();
        int            pend;
        int            q[$];
        int            rr;
        bit            m_spur;
        logic [AW-1:0] m_addr;
        logic          m_we;
        logic [DW-1:0] m_wd;
        int            w;
        logic [NR-1:0] exp_gnt;
        logic [NR-1:0] exp_rv;
        do_reset();
        pend = -1; rr = 0; m_spur = 1'b0; m_addr = '0; m_we = 1'b0; m_wd = '0;
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 63) == 0);
            req    = NR'($urandom);
            addr   = {$urandom, $urandom};
            wdata  = {$urandom, $urandom};
            we     = NR'($urandom);
            hgnt   = ($urandom_range(0, 3) != 0);
            hvalid = ($urandom_range(0, 2) == 0);
            hrdata = $urandom;
            herr   = 1'($urandom);
            #1;
            w = -1;
            if (pend < 0 && req != '0 && (q.size() < DEP || (hvalid && q.size() > 0))) begin
                for (int k = 0; k < NR; k++) begin
                    int j;
                    j = (rr + k) % NR;
                    if (w < 0 && req[j]) w = j;
                end
            end
            exp_gnt = (w >= 0) ? (NR'(1) << w) : '0;
            exp_rv  = (hvalid && q.size() > 0) ? (NR'(1) << q[0]) : '0;
            if (!rst) begin
                total++; if (gnt !== exp_gnt)   begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt); end
                total++; if (rvalid !== exp_rv) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, rvalid, exp_rv); end
                total++; if (hreq !== (pend >= 0)) begin bad++; $display("FAIL rnd_hreq cyc=%0d got=%b exp=%b", c, hreq, pend >= 0); end
                total++; if (haddr !== m_addr)  begin bad++; $display("FAIL rnd_haddr cyc=%0d got=%h exp=%h", c, haddr, m_addr); end
                total++; if (hwe !== m_we)      begin bad++; $display("FAIL rnd_hwe cyc=%0d got=%b exp=%b", c, hwe, m_we); end
                total++; if (hwdata !== m_wd)   begin bad++; $display("FAIL rnd_hwdata cyc=%0d got=%h exp=%h", c, hwdata, m_wd); end
                total++; if (spur !== m_spur)   begin bad++; $display("FAIL rnd_spur cyc=%0d got=%b exp=%b", c, spur, m_spur); end
                if (exp_rv != '0) begin
                    total++; if (rdata !== hrdata || rerr !== herr) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h/%b exp=%h/%b", c, rdata, rerr, hrdata, herr); end
                end
            end
            if (rst) begin
                q.delete(); pend = -1; rr = 0; m_spur = 1'b0;
                m_addr = '0; m_we = 1'b0; m_wd = '0;
            end else begin
                if (hvalid) begin
                    if (q.size() > 0) void'(q.pop_front());
                    else m_spur = 1'b1;
                end
                if (pend >= 0) begin
                    if (hgnt) begin
                        q.push_back(pend);
                        rr = (pend + 1) % NR;
                        pend = -1;
                    end
                end else if (w >= 0) begin
                    pend   = w;
                    m_addr = addr[w*AW +: AW];
                    m_we   = we[w];
                    m_wd   = wdata[w*DW +: DW];
                end
            end
            nxt();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_fairness();
        test_backpressure();
        test_fifo_full();
        test_push_pop();
        test_spurious_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
